// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/shift/logic operations plus a multi-cycle
// shift-add multiplier.
//
// Ports:
//   clk    - clock, all state changes on its rising edge
//   rst_n  - asynchronous active-low reset
//   start  - issue request, sampled only while busy is low
//   ctrl   - operation select (0..9 legal, 10..15 illegal)
//   num    - unsigned shift amount
//   a, b   - operands
//   y      - registered result
//   done   - one-cycle pulse marking a new y
//   busy   - high while a multiply is in progress
//   carry  - carry / borrow / overflow flag
//   zero   - high when the written y is all zeros
//   err    - high when the completed ctrl code was illegal
`timescale 1ns/1ps
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [SHW-1:0]   num,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             done,
  output logic             busy,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpSll = 4'd2;
  localparam logic [3:0] OpSla = 4'd3;
  localparam logic [3:0] OpSrl = 4'd4;
  localparam logic [3:0] OpSra = 4'd5;
  localparam logic [3:0] OpMul = 4'd6;
  localparam logic [3:0] OpInc = 4'd7;
  localparam logic [3:0] OpDec = 4'd8;
  localparam logic [3:0] OpAnd = 4'd9;

  typedef enum logic {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic                 done_q, done_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  // Single-cycle datapath
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       inc_ext;
  logic [2*WIDTH-1:0]   shl_ext;
  logic [WIDTH-1:0]     alu_y;
  logic                 alu_c;
  logic                 alu_err;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    sum_ext = {1'b0, a} + {1'b0, b};
    inc_ext = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    // Upper half collects every bit pushed past the MSB.
    shl_ext = {{WIDTH{1'b0}}, a} << num;
    case (ctrl)
      OpAdd: begin
        alu_y = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
      end
      OpSub: begin
        alu_y = a - b;
        alu_c = (a < b);
      end
      OpSll: begin
        alu_y = shl_ext[WIDTH-1:0];
        alu_c = |shl_ext[2*WIDTH-1:WIDTH];
      end
      OpSla: begin
        alu_y = {a[WIDTH-1], shl_ext[WIDTH-2:0]};
        alu_c = |shl_ext[2*WIDTH-1:WIDTH];
      end
      OpSrl: alu_y = a >> num;
      OpSra: alu_y = $unsigned($signed(a) >>> num);
      OpInc: begin
        alu_y = inc_ext[WIDTH-1:0];
        alu_c = inc_ext[WIDTH];
      end
      OpDec: begin
        alu_y = a - {{(WIDTH-1){1'b0}}, 1'b1};
        alu_c = (a == '0);
      end
      OpAnd: alu_y = a & b;
      OpMul: alu_y = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    done_d   = 1'b0;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (ctrl == OpMul) begin
            // Multiplier bit 0 is consumed on the issue edge so that the
            // remaining WIDTH-1 steps finish exactly WIDTH cycles after start.
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = CntW'(WIDTH - 1);
            state_d  = StMul;
          end else begin
            y_d     = alu_y;
            carry_d = alu_c;
            zero_d  = (alu_y == '0);
            err_d   = alu_err;
            done_d  = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          y_d     = acc_step[WIDTH-1:0];
          carry_d = |acc_step[2*WIDTH-1:WIDTH];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      y_q      <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign y     = y_q;
  assign done  = done_q;
  assign busy  = (state_q == StMul);
  assign carry = carry_q;
  assign zero  = zero_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
`timescale 1ns/1ps
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [4:0]  num;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        done;
  logic        busy;
  logic        carry;
  logic        zero;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ctrl  (ctrl),
    .num   (num),
    .a     (a),
    .b     (b),
    .y     (y),
    .done  (done),
    .busy  (busy),
    .carry (carry),
    .zero  (zero),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] n);
    start = 1'b1;
    ctrl  = c;
    a     = aa;
    b     = bb;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  // Single-cycle op: result, flags and done must appear right after the issue edge.
  task automatic alu_op(input string tag, input logic [3:0] c, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [4:0] n,
                        input logic [31:0] ey, input logic ec);
    issue(c, aa, bb, n);
    check({tag, ".y"}, y, ey);
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    check({tag, ".zero"}, 32'(zero), 32'(ey == 32'd0));
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  // Multiply: counts busy cycles until done, bounded; optionally injects an ADD start
  // mid-operation that must be ignored. Returns in the done cycle.
  task automatic mul_run(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] ey, input logic ec, input bit inject);
    int busy_cnt;
    bit got;
    busy_cnt = 0;
    got = 1'b0;
    issue(4'd6, aa, bb, 5'd0);
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (inject && i == 5) begin
          start = 1'b1;
          ctrl  = 4'd0;
          a     = 32'd1;
          b     = 32'd1;
        end else begin
          start = 1'b0;
        end
        tick();
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd31);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".y"}, y, ey);
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    check({tag, ".zero"}, 32'(zero), 32'(ey == 32'd0));
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  int dcount;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = 4'd0;
    num   = 5'd0;
    a     = 32'd0;
    b     = 32'd0;
    #3;
    check("rst.y", y, 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.carry", 32'(carry), 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    tick();
    tick();

    // Release reset and issue immediately: first edge after release must accept.
    rst_n = 1'b1;
    alu_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);
    tick();
    check("hold.done", 32'(done), 32'd0);
    check("hold.y", y, 32'd0);
    check("hold.carry", 32'(carry), 32'd1);
    check("hold.zero", 32'(zero), 32'd1);

    alu_op("add_nc", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0);
    alu_op("sub_borrow", 4'd1, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b1);
    alu_op("sub_nb", 4'd1, 32'd7, 32'd5, 5'd0, 32'd2, 1'b0);
    alu_op("sra", 4'd5, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b0);
    alu_op("sra_n0", 4'd5, 32'h1234_5678, 32'd0, 5'd0, 32'h1234_5678, 1'b0);
    alu_op("sla", 4'd3, 32'h4000_0001, 32'd0, 5'd1, 32'h0000_0002, 1'b0);
    alu_op("sla_c", 4'd3, 32'hC000_0001, 32'd0, 5'd1, 32'h8000_0002, 1'b1);
    alu_op("sll_c", 4'd2, 32'hC000_0001, 32'd0, 5'd2, 32'h0000_0004, 1'b1);
    alu_op("sll_n0", 4'd2, 32'h8234_5678, 32'd0, 5'd0, 32'h8234_5678, 1'b0);
    alu_op("srl", 4'd4, 32'h8000_0000, 32'd0, 5'd31, 32'd1, 1'b0);
    alu_op("inc_wrap", 4'd7, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0, 1'b1);
    alu_op("inc", 4'd7, 32'd7, 32'd0, 5'd0, 32'd8, 1'b0);
    alu_op("dec_wrap", 4'd8, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    alu_op("dec", 4'd8, 32'd8, 32'd0, 5'd0, 32'd7, 1'b0);
    alu_op("and", 4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0);

    // Illegal codes, then a legal op clears err.
    issue(4'd12, 32'h1234_5678, 32'hFFFF_FFFF, 5'd3);
    check("ill12.y", y, 32'd0);
    check("ill12.err", 32'(err), 32'd1);
    check("ill12.zero", 32'(zero), 32'd1);
    check("ill12.carry", 32'(carry), 32'd0);
    check("ill12.done", 32'(done), 32'd1);
    issue(4'd15, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("ill15.err", 32'(err), 32'd1);
    alu_op("and_after_ill", 4'd9, 32'hFFFF_FFFF, 32'h0000_00FF, 5'd0, 32'h0000_00FF, 1'b0);

    // Multiply with an ignored start mid-flight, then back-to-back INC in the done cycle.
    mul_run("mul_a", 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b1, 1'b1);
    start = 1'b1;
    ctrl  = 4'd7;
    a     = 32'h41;
    tick();
    start = 1'b0;
    check("b2b.done", 32'(done), 32'd1);
    check("b2b.y", y, 32'h42);
    check("b2b.carry", 32'(carry), 32'd0);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dcount++;
    end
    check("b2b.extra_done", 32'(dcount), 32'd0);
    check("b2b.y_hold", y, 32'h42);

    mul_run("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    mul_run("mul_small", 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    mul_run("mul_zero", 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of a multiply aborts it.
    issue(4'd12, 32'd0, 32'd0, 5'd0);
    issue(4'd6, 32'd3, 32'd5, 5'd0);
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst.busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.y", y, 32'd0);
    check("mid_rst.done", 32'(done), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.carry", 32'(carry), 32'd0);
    check("mid_rst.zero", 32'(zero), 32'd0);
    check("mid_rst.err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    check("post_rst.no_done", 32'(dcount), 32'd0);
    check("post_rst.y", y, 32'd0);
    alu_op("post_rst_add", 4'd0, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
